// File: rtl/led_rgb_duty_decoder_pkg.sv
// Shared constants, sample classification type and helpers for the RGB PWM duty decoder.
// Build option LED_DECODE_ERR_EN enables mixed-sample error reporting.
package led_rgb_duty_decoder_pkg;

    localparam int WINDOW_LEN = 256;
    localparam int COUNT_W    = 9;
    localparam int WIN_W      = 8;
    localparam int NIB_W      = 4;
    localparam int BRIGHT_W   = 8;
    localparam int N_CH       = 3;

    localparam logic [1:0] LVL_OFF  = 2'b00;
    localparam logic [1:0] LVL_LOW  = 2'b01;
    localparam logic [1:0] LVL_MID  = 2'b10;
    localparam logic [1:0] LVL_HIGH = 2'b11;

    typedef enum logic [1:0] {
        SAMPLE_LOW   = 2'd0,
        SAMPLE_HIGH  = 2'd1,
        SAMPLE_MIXED = 2'd2
    } sample_t;

    function automatic logic [COUNT_W-1:0] abs_diff(
        input logic [COUNT_W-1:0] a,
        input logic [COUNT_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/led_duty_channel.sv
// One colour channel: samples its PWM nibble, counts high samples over a window and
// classifies the final count against brightness-derived targets. Honours LED_DECODE_ERR_EN.
module led_duty_channel
    import led_rgb_duty_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                win_start,
    input  logic [NIB_W-1:0]    nibble,
    input  logic [BRIGHT_W-1:0] b_lat,
    output logic [1:0]          level,
    output logic                err
);

    sample_t              samp;
    logic                 is_high;
    logic [COUNT_W-1:0]   count_reg;
    logic [COUNT_W-1:0]   count_total;
    logic [COUNT_W-1:0]   t1, t2, t3;
    logic [COUNT_W-1:0]   d1, d2, d3;

    always_comb begin
        samp = SAMPLE_MIXED;
        if (nibble == 4'b1111)
            samp = SAMPLE_HIGH;
        else if (nibble == 4'b0000)
            samp = SAMPLE_LOW;
    end

`ifdef LED_DECODE_ERR_EN
    logic mixed_reg;
    logic mixed_total;

    assign is_high     = (samp == SAMPLE_HIGH);
    assign mixed_total = (win_start ? 1'b0 : mixed_reg) | (samp == SAMPLE_MIXED);
    assign err         = mixed_total | ((b_lat == '0) && (count_total != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mixed_reg <= 1'b0;
        else if (clear)
            mixed_reg <= 1'b0;
        else
            mixed_reg <= mixed_total;
    end
`else
    // Without error reporting a mixed nibble is resolved by its MSB.
    assign is_high = (samp == SAMPLE_HIGH) | ((samp == SAMPLE_MIXED) & nibble[3]);
    assign err     = 1'b0;
`endif

    // count_total includes the current sample, so at window end it is the full-window count.
    assign count_total = (win_start ? '0 : count_reg) + {{(COUNT_W-1){1'b0}}, is_high};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else if (clear)
            count_reg <= '0;
        else
            count_reg <= count_total;
    end

    assign t1 = {1'b0, b_lat} / 9'd3;
    assign t2 = {1'b0, b_lat} / 9'd2;
    assign t3 = {1'b0, b_lat};
    assign d1 = abs_diff(count_total, t1);
    assign d2 = abs_diff(count_total, t2);
    assign d3 = abs_diff(count_total, t3);

    // Ties favour the lower code because each test uses <=.
    always_comb begin
        level = LVL_OFF;
        if (count_total == '0 || b_lat == '0)
            level = LVL_OFF;
        else if (d1 <= d2 && d1 <= d3)
            level = LVL_LOW;
        else if (d2 <= d3)
            level = LVL_MID;
        else
            level = LVL_HIGH;
    end

endmodule

// File: rtl/led_rgb_duty_decoder.sv
// Recovers 2-bit brightness levels for R, G and B from a 12-bit PWM bus over 256-sample windows.
// Define LED_DECODE_ERR_EN to report mixed-sample and zero-brightness decode errors.
module led_rgb_duty_decoder
    import led_rgb_duty_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         led_RGB,
    input  logic [7:0]          LedRGBBright,
    input  logic                clear,
    output logic [5:0]          interrupt,
    output logic                level_valid,
    output logic [2:0]          err
);

    logic [WIN_W-1:0]    win_cnt_reg;
    logic [BRIGHT_W-1:0] b_lat_reg;
    logic                win_start;
    logic                win_end;
    logic [1:0]          ch_level [N_CH];
    logic [N_CH-1:0]     ch_err;

    assign win_start = (win_cnt_reg == '0);
    assign win_end   = (win_cnt_reg == WIN_W'(WINDOW_LEN - 1));

    // Channel index 0 is B, 1 is G, 2 is R, matching the nibble order on led_RGB.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            led_duty_channel u_ch (
                .clk       (clk),
                .reset     (reset),
                .clear     (clear),
                .win_start (win_start),
                .nibble    (led_RGB[gi*NIB_W +: NIB_W]),
                .b_lat     (b_lat_reg),
                .level     (ch_level[gi]),
                .err       (ch_err[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_reg <= '0;
            b_lat_reg   <= '0;
            interrupt   <= '0;
            level_valid <= 1'b0;
            err         <= '0;
        end else if (clear) begin
            win_cnt_reg <= '0;
            level_valid <= 1'b0;
        end else begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            if (win_start)
                b_lat_reg <= LedRGBBright;
            level_valid <= win_end;
            if (win_end) begin
                interrupt <= {ch_level[2], ch_level[1], ch_level[0]};
                err       <= ch_err;
            end
        end
    end

endmodule

// File: tb/tb_led_rgb_duty_decoder.sv
// Directed self-checking bench for led_rgb_duty_decoder; expectations follow LED_DECODE_ERR_EN.
module tb_led_rgb_duty_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] led_RGB;
    logic [7:0]  LedRGBBright;
    logic        clear;
    logic [5:0]  interrupt;
    logic        level_valid;
    logic [2:0]  err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    led_rgb_duty_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .led_RGB      (led_RGB),
        .LedRGBBright (LedRGBBright),
        .clear        (clear),
        .interrupt    (interrupt),
        .level_valid  (level_valid),
        .err          (err)
    );

    // Drives one full window starting at counter 0; brightness is corrupted after the
    // first sample so a missing latch shows up in the result.
    task automatic run_window(input string name, input logic [7:0] br,
                              input int n_r, input int n_g, input int n_b,
                              input logic [3:0] fill_b, input int m_b,
                              input logic [5:0] exp_int, input logic [2:0] exp_err);
        logic [3:0] nr, ng, nb;
        for (int i = 0; i < 256; i++) begin
            nr = (i < n_r) ? 4'hF : 4'h0;
            ng = (i < n_g) ? 4'hF : 4'h0;
            nb = (i < n_b) ? 4'hF : ((i < n_b + m_b) ? fill_b : 4'h0);
            led_RGB = {nr, ng, nb};
            LedRGBBright = (i == 0) ? br : ~br;
            @(posedge clk); #1;
            if (i == 0 || i == 128) begin
                tests++;
                if (level_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL %s early_valid i=%0d got %b want 0", name, i, level_valid);
                end
            end
        end
        tests++;
        if (level_valid !== 1'b1) begin
            failed++;
            $display("FAIL %s level_valid got %b want 1", name, level_valid);
        end
        tests++;
        if (interrupt !== exp_int) begin
            failed++;
            $display("FAIL %s interrupt got %b want %b", name, interrupt, exp_int);
        end
        tests++;
        if (err !== exp_err) begin
            failed++;
            $display("FAIL %s err got %b want %b", name, err, exp_err);
        end
        $display("[TB] %s: interrupt=%b err=%b level_valid=%b", name, interrupt, err, level_valid);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        led_RGB = 12'h000;
        LedRGBBright = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (interrupt !== 6'b0) begin failed++; $display("FAIL reset interrupt got %b want 000000", interrupt); end
        tests++;
        if (level_valid !== 1'b0) begin failed++; $display("FAIL reset level_valid got %b want 0", level_valid); end
        tests++;
        if (err !== 3'b0) begin failed++; $display("FAIL reset err got %b want 000", err); end
        $display("[TB] reset: interrupt=%b err=%b level_valid=%b", interrupt, err, level_valid);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_window("r85_low", 8'd255, 85, 0, 0, 4'h0, 0, 6'b01_00_00, 3'b000);
    endtask

    task automatic test_levels();
        run_window("g127_b255", 8'd255, 0, 127, 255, 4'h0, 0, 6'b00_10_11, 3'b000);
    endtask

    task automatic test_zero_bright();
`ifdef LED_DECODE_ERR_EN
        run_window("bright0_r5", 8'd0, 5, 0, 0, 4'h0, 0, 6'b00_00_00, 3'b100);
`else
        run_window("bright0_r5", 8'd0, 5, 0, 0, 4'h0, 0, 6'b00_00_00, 3'b000);
`endif
    endtask

    task automatic test_mixed();
`ifdef LED_DECODE_ERR_EN
        run_window("mixed_b", 8'd255, 0, 0, 0, 4'b1010, 10, 6'b00_00_00, 3'b001);
`else
        run_window("mixed_b", 8'd255, 0, 0, 0, 4'b1010, 10, 6'b00_00_01, 3'b000);
`endif
    endtask

    // Brightness 12 gives targets 4/6/12: count 9 ties MID/HIGH, 10 -> HIGH, 256 -> HIGH.
    task automatic test_tie_and_full();
        run_window("tie_full", 8'd12, 9, 10, 256, 4'h0, 0, 6'b10_11_11, 3'b000);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 256; i++) begin
            led_RGB = {(i < 85) ? 4'hF : 4'h0, 8'h00};
            LedRGBBright = 8'd255;
            clear = (i == 255);
            @(posedge clk); #1;
        end
        tests++;
        if (level_valid !== 1'b0) begin failed++; $display("FAIL clear level_valid got %b want 0", level_valid); end
        tests++;
        if (interrupt !== 6'b10_11_11) begin failed++; $display("FAIL clear interrupt got %b want 101111", interrupt); end
        $display("[TB] clear: interrupt=%b level_valid=%b", interrupt, level_valid);
        clear = 1'b0;
        run_window("after_clear", 8'd255, 0, 85, 0, 4'h0, 0, 6'b00_01_00, 3'b000);
    endtask

    task automatic test_reset_mid();
        int got;
        for (int i = 0; i <= 100; i++) begin
            led_RGB = 12'hFFF;
            LedRGBBright = 8'd255;
            @(posedge clk); #1;
        end
        #3 reset = 1'b1;
        #1;
        tests++;
        if (interrupt !== 6'b0) begin failed++; $display("FAIL reset_mid interrupt got %b want 000000", interrupt); end
        tests++;
        if (level_valid !== 1'b0) begin failed++; $display("FAIL reset_mid level_valid got %b want 0", level_valid); end
        tests++;
        if (err !== 3'b0) begin failed++; $display("FAIL reset_mid err got %b want 000", err); end
        @(posedge clk); #1;
        reset = 1'b0;
        got = 0;
        for (int c = 1; c <= 300; c++) begin
            led_RGB = {(c - 1 < 85) ? 4'hF : 4'h0, 8'h00};
            LedRGBBright = (c == 1) ? 8'd255 : 8'd0;
            @(posedge clk); #1;
            if (level_valid === 1'b1) begin
                got = c;
                break;
            end
        end
        tests++;
        if (got != 256) begin failed++; $display("FAIL reset_mid latency got %0d want 256", got); end
        tests++;
        if (interrupt !== 6'b01_00_00) begin failed++; $display("FAIL reset_mid interrupt got %b want 010000", interrupt); end
        $display("[TB] reset_mid: latency=%0d interrupt=%b", got, interrupt);
        @(posedge clk); #1;
        tests++;
        if (level_valid !== 1'b0) begin failed++; $display("FAIL pulse_width level_valid got %b want 0", level_valid); end
        tests++;
        if (interrupt !== 6'b01_00_00) begin failed++; $display("FAIL hold interrupt got %b want 010000", interrupt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_levels();
        test_zero_bright();
        test_mixed();
        test_tie_and_full();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
